// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle carried down the pipeline.
package ctrl_pkg;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU operation codes (low four bits of alu_control_e)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       alu_src_a;
    logic [1:0] result_src;
    logic [2:0] branch_cond;
    logic [3:0] alu_ctrl;
  } ctrl_bundle_t;

  // Fields still needed once the instruction has left EX
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
  } wb_stage_t;

  // Register-register / register-immediate ALU op from funct3; alt selects SUB/SRA
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decode: op/funct3/funct7 -> control bundle, imm format, illegal flag.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic         instr_valid,
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output ctrl_bundle_t ctrl,
  output logic [2:0]   imm_src,
  output logic         illegal
);

  ctrl_bundle_t dec;
  logic         bad;

  // Decode every field, then squash the whole bundle for illegal or absent instructions
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    bad       = 1'b0;
    imm_src   = IMM_I;
    case (op)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        bad            = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = IMM_S;
        bad           = (funct3 != 3'b010);
      end
      OP_R: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000001) begin
          dec.alu_ctrl = ALU_MUL;
          bad          = !M_EXT || (funct3 != 3'b000);
        end else begin
          dec.alu_ctrl = alu_from_f3(funct3, funct7[5]);
          // alt encoding only exists for SUB and SRA
          bad = !((funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (funct3)
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            bad          = (funct7 != 7'b0000000);
          end
          3'b101: begin
            dec.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            bad          = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          // funct7 is part of the immediate here
          default: dec.alu_ctrl = alu_from_f3(funct3, 1'b0);
        endcase
      end
      OP_BR: begin
        dec.branch      = 1'b1;
        dec.branch_cond = funct3;
        imm_src         = IMM_B;
        dec.alu_ctrl    = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        bad             = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = 1'b1;
        dec.result_src = RES_PC4;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
        bad            = (funct3 != 3'b000);
      end
      OP_LUI: begin
        // datapath forces rs1 to x0, so an add of the immediate suffices
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
        imm_src       = IMM_U;
      end
      default: bad = 1'b1;
    endcase
    illegal = instr_valid & bad;
    ctrl    = (instr_valid && !bad) ? dec : '0;
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: decode, then ID/EX (stall/flush), EX/MEM and MEM/WB registers.
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,    // must be >= 4
  parameter bit M_EXT       = 1'b0,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid_d,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic [2:0]           imm_src_d,
  output logic                 illegal_d,
  output logic [ALUCTRL_W-1:0] alu_control_e,
  output logic                 alu_src_e,
  output logic                 alu_src_a_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic [2:0]           branch_cond_e,
  output logic                 valid_e,
  output logic                 valid_m,
  output logic                 valid_w,
  output logic                 mem_write_m,
  output logic                 reg_write_m,
  output logic                 reg_write_w,
  output logic [1:0]           result_src_m,
  output logic [1:0]           result_src_w
);

  ctrl_bundle_t dec_bundle;
  ctrl_bundle_t de_d, de_q;
  mem_stage_t   em_d, em_q;
  wb_stage_t    mw_d, mw_q;
  logic         hold_e;

  ctrl_decoder #(.M_EXT(M_EXT)) u_dec (
    .instr_valid (instr_valid_d),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .ctrl        (dec_bundle),
    .imm_src     (imm_src_d),
    .illegal     (illegal_d)
  );

  // Flush beats stall; a held ID/EX sends a bubble on so its instruction is not duplicated
  assign hold_e = stall_e & ~flush_e;

  // ID/EX next value: flush > stall > load
  always_comb begin
    de_d = dec_bundle;
    if (flush_e) begin
      if (ZERO_BUBBLE) begin
        de_d = '0;
      end else begin
        de_d.valid     = 1'b0;
        de_d.reg_write = 1'b0;
        de_d.mem_write = 1'b0;
      end
    end else if (stall_e) begin
      de_d = de_q;
    end
  end

  // EX/MEM next value, enables gated by the stage valid
  always_comb begin
    em_d.valid      = de_q.valid & ~hold_e;
    em_d.reg_write  = de_q.reg_write & em_d.valid;
    em_d.mem_write  = de_q.mem_write & em_d.valid;
    em_d.result_src = (ZERO_BUBBLE && !em_d.valid) ? RES_ALU : de_q.result_src;
  end

  // MEM/WB next value, enables gated by the stage valid
  always_comb begin
    mw_d.valid      = em_q.valid;
    mw_d.reg_write  = em_q.reg_write & em_q.valid;
    mw_d.result_src = (ZERO_BUBBLE && !em_q.valid) ? RES_ALU : em_q.result_src;
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // Zero-extend the 4-bit code to the configured width
  always_comb begin
    alu_control_e      = '0;
    alu_control_e[3:0] = de_q.alu_ctrl;
  end

  assign alu_src_e     = de_q.alu_src;
  assign alu_src_a_e   = de_q.alu_src_a;
  assign branch_e      = de_q.branch;
  assign jump_e        = de_q.jump;
  assign branch_cond_e = de_q.branch_cond;
  assign valid_e       = de_q.valid;
  assign valid_m       = em_q.valid;
  assign mem_write_m   = em_q.mem_write;
  assign reg_write_m   = em_q.reg_write;
  assign result_src_m  = em_q.result_src;
  assign valid_w       = mw_q.valid;
  assign reg_write_w   = mw_q.reg_write;
  assign result_src_w  = mw_q.result_src;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe with an M/W-stage scoreboard queue.
module tb_control_unit_pipe;

  logic       clk = 1'b0;
  logic       rst, instr_valid_d, stall_e, flush_e;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  // Main DUT: M_EXT=0, widened ALU control
  logic [2:0] imm_src_d;
  logic       illegal_d;
  logic [5:0] alu_control_e;
  logic       alu_src_e, alu_src_a_e, branch_e, jump_e;
  logic [2:0] branch_cond_e;
  logic       valid_e, valid_m, valid_w, mem_write_m, reg_write_m, reg_write_w;
  logic [1:0] result_src_m, result_src_w;

  // Second DUT: M_EXT=1
  logic [2:0] x_imm_src_d;
  logic       x_illegal_d;
  logic [3:0] x_alu_control_e;
  logic       x_alu_src_e, x_alu_src_a_e, x_branch_e, x_jump_e;
  logic [2:0] x_branch_cond_e;
  logic       x_valid_e, x_valid_m, x_valid_w, x_mem_write_m, x_reg_write_m, x_reg_write_w;
  logic [1:0] x_result_src_m, x_result_src_w;

  always #5 clk = ~clk;

  control_unit_pipe #(.ALUCTRL_W(6), .M_EXT(1'b0), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid_d(instr_valid_d), .op(op), .funct3(funct3),
    .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .imm_src_d(imm_src_d),
    .illegal_d(illegal_d), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .alu_src_a_e(alu_src_a_e), .branch_e(branch_e), .jump_e(jump_e),
    .branch_cond_e(branch_cond_e), .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
    .mem_write_m(mem_write_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_m(result_src_m), .result_src_w(result_src_w)
  );

  control_unit_pipe #(.ALUCTRL_W(4), .M_EXT(1'b1), .ZERO_BUBBLE(1'b1)) dut_m (
    .clk(clk), .rst(rst), .instr_valid_d(instr_valid_d), .op(op), .funct3(funct3),
    .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .imm_src_d(x_imm_src_d),
    .illegal_d(x_illegal_d), .alu_control_e(x_alu_control_e), .alu_src_e(x_alu_src_e),
    .alu_src_a_e(x_alu_src_a_e), .branch_e(x_branch_e), .jump_e(x_jump_e),
    .branch_cond_e(x_branch_cond_e), .valid_e(x_valid_e), .valid_m(x_valid_m), .valid_w(x_valid_w),
    .mem_write_m(x_mem_write_m), .reg_write_m(x_reg_write_m), .reg_write_w(x_reg_write_w),
    .result_src_m(x_result_src_m), .result_src_w(x_result_src_w)
  );

  typedef enum {K_RAND, K_NONE, K_ADD, K_SUB, K_LW, K_SW, K_BEQ, K_JAL,
                K_ADDI, K_SRAI, K_LUI, K_BAD, K_MUL} kind_t;

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic       iv, ill; logic [2:0] imm;
    logic       v, rw, mw, br, jp, asrc, asrca;
    logic [1:0] rs; logic [2:0] bc; logic [3:0] alu;
  } ref_t;

  typedef struct packed { logic v, rw, mw; logic [1:0] rs; } stg_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses;
  ref_t me;          // expected ID/EX contents
  stg_t sb[$];       // sb[0] expected at W, sb[1] expected at M

  // Expected encoding and decode for each directed instruction
  function automatic ref_t ref_of(input kind_t k);
    ref_t r;
    r = '0;
    r.iv = 1'b1;
    case (k)
      K_NONE: begin r.op = 7'b0110011; r.iv = 1'b0; end
      K_ADD:  begin r.op = 7'b0110011; r.v = 1; r.rw = 1; end
      K_SUB:  begin r.op = 7'b0110011; r.f7 = 7'b0100000; r.v = 1; r.rw = 1; r.alu = 4'd1; end
      K_LW:   begin r.op = 7'b0000011; r.f3 = 3'b010; r.v = 1; r.rw = 1; r.asrc = 1; r.rs = 2'b01; end
      K_SW:   begin r.op = 7'b0100011; r.f3 = 3'b010; r.v = 1; r.mw = 1; r.asrc = 1; r.imm = 3'b001; end
      K_BEQ:  begin r.op = 7'b1100011; r.v = 1; r.br = 1; r.imm = 3'b010; r.alu = 4'd1; end
      K_JAL:  begin r.op = 7'b1101111; r.v = 1; r.rw = 1; r.jp = 1; r.asrc = 1; r.asrca = 1;
                    r.rs = 2'b10; r.imm = 3'b011; end
      K_ADDI: begin r.op = 7'b0010011; r.f7 = 7'b0100000; r.v = 1; r.rw = 1; r.asrc = 1; end
      K_SRAI: begin r.op = 7'b0010011; r.f3 = 3'b101; r.f7 = 7'b0100000; r.v = 1; r.rw = 1;
                    r.asrc = 1; r.alu = 4'd9; end
      K_LUI:  begin r.op = 7'b0110111; r.f3 = 3'b110; r.v = 1; r.rw = 1; r.asrc = 1; r.imm = 3'b100; end
      K_BAD:  begin r.op = 7'b1111111; r.ill = 1; end
      K_MUL:  begin r.op = 7'b0110011; r.f7 = 7'b0000001; r.ill = 1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one decode slot, update the reference pipeline, clock, then compare all stages
  task automatic step(input kind_t k, input logic st, input logic fl, input logic r);
    ref_t e;
    stg_t m_in, z;
    e = ref_of(k);
    z = '0;
    rst = r; stall_e = st; flush_e = fl;
    if (k == K_RAND) begin
      instr_valid_d = 1'($urandom); op = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    end else begin
      instr_valid_d = e.iv; op = e.op; funct3 = e.f3; funct7 = e.f7;
    end
    #1;
    if (k != K_RAND) begin
      chk("imm_src_d", 32'(imm_src_d), 32'(e.imm));
      chk("illegal_d", 32'(illegal_d), 32'(e.ill));
    end
    if (k == K_MUL) chk("mext_illegal_d", 32'(x_illegal_d), 32'd0);

    if (r) begin
      me = '0;
      sb.delete();
      sb.push_back(z);
      sb.push_back(z);
    end else begin
      m_in = z;
      if (!(st && !fl)) begin
        m_in.v  = me.v;
        m_in.rw = me.rw & me.v;
        m_in.mw = me.mw & me.v;
        m_in.rs = me.rs;
      end
      sb.push_back(m_in);
      void'(sb.pop_front());
      if (fl) me = '0;
      else if (!st) me = e;
    end

    @(posedge clk); #1;
    chk("valid_e",       32'(valid_e),       32'(me.v));
    chk("alu_control_e", 32'(alu_control_e), 32'(me.alu));
    chk("alu_src_e",     32'(alu_src_e),     32'(me.asrc));
    chk("alu_src_a_e",   32'(alu_src_a_e),   32'(me.asrca));
    chk("branch_e",      32'(branch_e),      32'(me.br));
    chk("jump_e",        32'(jump_e),        32'(me.jp));
    chk("branch_cond_e", 32'(branch_cond_e), 32'(me.bc));
    chk("valid_m",       32'(valid_m),       32'(sb[1].v));
    chk("reg_write_m",   32'(reg_write_m),   32'(sb[1].rw));
    chk("mem_write_m",   32'(mem_write_m),   32'(sb[1].mw));
    chk("result_src_m",  32'(result_src_m),  32'(sb[1].rs));
    chk("valid_w",       32'(valid_w),       32'(sb[0].v));
    chk("reg_write_w",   32'(reg_write_w),   32'(sb[0].rw));
    chk("result_src_w",  32'(result_src_w),  32'(sb[0].rs));
    if (mem_write_m === 1'b1) pulses++;
    if (k == K_MUL && !r && !st && !fl) begin
      chk("mext_alu_control_e", 32'(x_alu_control_e), 32'd10);
      chk("mext_valid_e",       32'(x_valid_e),       32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0; instr_valid_d = 1'b0;
    op = '0; funct3 = '0; funct7 = '0; pulses = 0; me = '0;

    // reset with random inputs
    step(K_RAND, 1'($urandom), 1'($urandom), 1'b1);
    step(K_RAND, 1'($urandom), 1'($urandom), 1'b1);

    // ALU, load, branch, jump through all stages
    step(K_SUB, 0, 0, 0);
    step(K_LW,  0, 0, 0);
    step(K_BEQ, 0, 0, 0);
    step(K_JAL, 0, 0, 0);
    repeat (3) step(K_NONE, 0, 0, 0);

    // store held in EX by two stall cycles, then flush+stall together
    pulses = 0;
    step(K_SW,  0, 0, 0);
    step(K_ADD, 1, 0, 0);
    step(K_ADD, 1, 0, 0);
    step(K_ADD, 0, 0, 0);
    step(K_ADDI, 1, 1, 0);
    chk("flush_over_stall_valid_e", 32'(valid_e), 32'd0);
    repeat (3) step(K_NONE, 0, 0, 0);
    chk("sw_mem_write_pulses", 32'(pulses), 32'd1);

    // illegal opcode and MUL without the M extension
    step(K_BAD, 0, 0, 0);
    step(K_MUL, 0, 0, 0);
    repeat (3) step(K_NONE, 0, 0, 0);

    // reset while a store sits in EX
    pulses = 0;
    step(K_SW,  0, 0, 0);
    step(K_ADD, 0, 0, 1);
    chk("rst_sw_mem_write_m", 32'(mem_write_m), 32'd0);
    repeat (3) step(K_NONE, 0, 0, 0);
    chk("rst_sw_pulses", 32'(pulses), 32'd0);

    // back-to-back stream keeps W busy every cycle
    for (int i = 0; i < 8; i++) begin
      step((i == 5) ? K_SRAI : (i == 6) ? K_LUI : K_ADDI, 0, 0, 0);
      if (i >= 2) chk("stream_valid_w", 32'(valid_w), 32'd1);
    end
    repeat (3) step(K_NONE, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
